// File: rtl/dino_motion_ctrl.sv
// Per-frame dino physics: jump / gravity / fast-fall / duck, stepped once per
// screenEnd rising edge, driving VGAController's dino_x/dino_y.
module dino_motion_ctrl #(
  parameter int GROUND_Y = 275,
  parameter int DINO_X   = 80,
  parameter int JUMP_VEL = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        screenEnd,
  input  logic        up,
  input  logic        down,
  output logic [31:0] dino_x,
  output logic [31:0] dino_y,
  output logic        airborne,
  output logic        ducking,
  output logic [15:0] jump_count
);

  localparam logic [1:0] RUN  = 2'd0;
  localparam logic [1:0] DUCK = 2'd1;
  localparam logic [1:0] RISE = 2'd2;
  localparam logic [1:0] FALL = 2'd3;

  localparam logic [9:0] GROUND    = 10'(GROUND_Y);
  localparam logic [9:0] TAKEOFF_Y = 10'(GROUND_Y - JUMP_VEL);
  localparam logic [7:0] TAKEOFF_V = 8'(JUMP_VEL - GRAVITY);
  localparam logic [7:0] GR        = 8'(GRAVITY);
  localparam logic [7:0] GR2       = 8'(2 * GRAVITY);
  localparam logic [7:0] MF        = 8'(MAX_FALL);

  logic [1:0]  state;
  logic [9:0]  y;
  logic [7:0]  vel;
  logic        jump_req, screenEnd_d, up_d, armed;

  logic        tick, up_edge, jump_now;
  logic [7:0]  g_eff, vn;
  logic [8:0]  vsum;
  logic [10:0] yn;
  logic [9:0]  y_rise;

  // armed blocks the phantom edge seen when screenEnd is already high as reset
  // releases (screenEnd_d restarts at 0); the first real tick needs a low first.
  assign tick     = screenEnd & ~screenEnd_d & armed;
  assign up_edge  = up & ~up_d;
  assign jump_now = jump_req | up_edge;

  always_comb begin
    g_eff  = down ? GR2 : GR;
    vsum   = {1'b0, vel} + {1'b0, g_eff};
    vn     = (vsum > {1'b0, MF}) ? MF : vsum[7:0];
    yn     = {1'b0, y} + {3'b0, vn};
    y_rise = (y > {2'b0, vel}) ? (y - {2'b0, vel}) : 10'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      y           <= GROUND;
      vel         <= 8'd0;
      jump_req    <= 1'b0;
      screenEnd_d <= 1'b0;
      up_d        <= 1'b0;
      armed       <= 1'b0;
      jump_count  <= 16'd0;
    end else begin
      screenEnd_d <= screenEnd;
      up_d        <= up;
      if (!screenEnd) armed <= 1'b1;

      if (tick)         jump_req <= 1'b0;
      else if (up_edge) jump_req <= 1'b1;

      if (tick) begin
        case (state)
          RUN, DUCK: begin
            if (jump_now) begin
              y          <= TAKEOFF_Y;
              vel        <= TAKEOFF_V;
              state      <= RISE;
              jump_count <= jump_count + 16'd1;
            end else begin
              y     <= GROUND;
              state <= down ? DUCK : RUN;
            end
          end
          RISE: begin
            y <= y_rise;
            if (vel <= g_eff) begin
              vel   <= 8'd0;
              state <= FALL;
            end else begin
              vel <= vel - g_eff;
            end
          end
          default: begin
            // Clamp the landing frame to the ground line.
            if (yn >= {1'b0, GROUND}) begin
              y     <= GROUND;
              vel   <= 8'd0;
              state <= down ? DUCK : RUN;
            end else begin
              y   <= yn[9:0];
              vel <= vn;
            end
          end
        endcase
      end
    end
  end

  assign dino_x   = 32'(DINO_X);
  assign dino_y   = {22'd0, y};
  assign airborne = (state == RISE) || (state == FALL);
  assign ducking  = (state == DUCK);

endmodule

// File: tb/tb_dino_motion_ctrl.sv
// Directed-vector bench for dino_motion_ctrl: table of per-frame steps with
// hand-computed positions, plus sequences for reset and edge-alignment cases.
module tb_dino_motion_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        screenEnd = 1'b0;
  logic        up = 1'b0;
  logic        down = 1'b0;
  logic [31:0] dino_x, dino_y;
  logic        airborne, ducking;
  logic [15:0] jump_count;

  dino_motion_ctrl dut (
    .clk(clk), .reset(reset), .screenEnd(screenEnd), .up(up), .down(down),
    .dino_x(dino_x), .dino_y(dino_y), .airborne(airborne), .ducking(ducking),
    .jump_count(jump_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        up;
    logic        down;
    logic [9:0]  y;
    logic        air;
    logic        duck;
    logic [15:0] jc;
  } vec_t;

  vec_t tbl[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  // Plain jump, ticks 1..24 (g=1, cap 12).
  int jump_y [24] = '{263, 252, 242, 233, 225, 218, 212, 207, 203, 200, 198, 197,
                      198, 200, 203, 207, 212, 218, 225, 233, 242, 252, 263, 275};
  // Jump with down held from tick 5 (g=2), ticks 1..16.
  int dj_y [16]   = '{263, 252, 242, 233, 225, 219, 215, 213,
                      215, 219, 225, 233, 243, 255, 267, 275};

  function automatic void add(logic r, logic u, logic d, int ey, logic ea, logic ed, int ejc);
    vec_t v;
    v.rst = r; v.up = u; v.down = d; v.y = 10'(ey); v.air = ea; v.duck = ed; v.jc = 16'(ejc);
    tbl.push_back(v);
  endfunction

  task automatic clk_n(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    screenEnd = 1'b1;
    clk_n(4);
    screenEnd = 1'b0;
    clk_n(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clk_n(2);
    reset = 1'b0;
    clk_n(2);
  endtask

  task automatic check(string name, logic [9:0] ey, logic ea, logic ed, logic [15:0] ejc);
    vec_cnt++;
    if (dino_y !== {22'd0, ey} || dino_x !== 32'd80 || airborne !== ea ||
        ducking !== ed || jump_count !== ejc) begin
      err_cnt++;
      $display("FAIL %s: got y=%0d x=%0d air=%b duck=%b jc=%0d, want y=%0d x=80 air=%b duck=%b jc=%0d",
               name, dino_y, dino_x, airborne, ducking, jump_count, ey, ea, ed, ejc);
    end
  endtask

  initial begin
    // idle
    add(1, 0, 0, 275, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 275, 0, 0, 0);
    // single jump
    add(1, 0, 0, 275, 0, 0, 0);
    for (int i = 0; i < 24; i++) add(0, i == 0, 0, jump_y[i], i < 23, 0, 1);
    // held up button: one jump only
    add(1, 0, 0, 275, 0, 0, 0);
    for (int i = 0; i < 40; i++) add(0, 1, 0, (i < 24) ? jump_y[i] : 275, i < 23, 0, 1);
    // duck on ground
    add(1, 0, 0, 275, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 275, 0, 1, 0);
    add(0, 0, 0, 275, 0, 0, 0);
    // fast-fall jump landing into duck
    add(1, 0, 0, 275, 0, 0, 0);
    for (int i = 0; i < 16; i++) add(0, i == 0, i >= 4, dj_y[i], i < 15, i == 15, 1);

    clk_n(2);
    foreach (tbl[k]) begin
      up   = tbl[k].up;
      down = tbl[k].down;
      if (tbl[k].rst) begin
        do_reset();
        check($sformatf("vec%0d_reset", k), tbl[k].y, tbl[k].air, tbl[k].duck, tbl[k].jc);
      end else begin
        clk_n(2);
        do_tick();
        check($sformatf("vec%0d", k), tbl[k].y, tbl[k].air, tbl[k].duck, tbl[k].jc);
      end
    end

    // up edge and screenEnd edge on the same clock: request counts for that tick
    up = 1'b0; down = 1'b0;
    do_reset();
    up = 1'b1; screenEnd = 1'b1;
    clk_n(4);
    screenEnd = 1'b0;
    clk_n(2);
    check("same_edge_takeoff", 263, 1, 0, 1);
    up = 1'b0;

    // up pressed mid-air is dropped, no jump after landing
    for (int t = 2; t <= 25; t++) begin
      if (t == 5) begin
        up = 1'b1; clk_n(2); up = 1'b0; clk_n(1);
      end
      do_tick();
      if (t == 5)  check("midair_press_t5", 225, 1, 0, 1);
      if (t == 24) check("midair_press_land", 275, 0, 0, 1);
      if (t == 25) check("no_double_jump", 275, 0, 0, 1);
    end

    // reset mid-air, screenEnd held high across release
    do_reset();
    up = 1'b1; clk_n(2);
    do_tick();
    up = 1'b0;
    for (int t = 2; t <= 6; t++) do_tick();
    check("pre_reset_airborne", 218, 1, 0, 1);
    reset = 1'b1; screenEnd = 1'b1; down = 1'b1;
    #1;
    check("async_reset", 275, 0, 0, 0);
    clk_n(3);
    reset = 1'b0;
    clk_n(4);
    check("held_screenEnd_no_tick", 275, 0, 0, 0);
    screenEnd = 1'b0;
    clk_n(2);
    screenEnd = 1'b1;
    clk_n(4);
    check("first_tick_after_release", 275, 0, 1, 0);
    screenEnd = 1'b0; down = 1'b0;
    clk_n(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
